// File: rtl/lsu_if.sv
// Request/response and memory-port bundle for the load/store unit.
// The slave modport is the LSU's view; master is the surrounding system.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_rdata;
    logic        resp_err;

    logic        mem_en;
    logic        mem_we;
    logic        mem_byte_enable;
    logic        mem_byte_select;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_wait;

    modport slave (
        input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_rdata, mem_wait,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_en, mem_we, mem_byte_enable, mem_byte_select, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        output resp_ready, mem_rdata, mem_wait,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_en, mem_we, mem_byte_enable, mem_byte_select, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu.sv
// Single-outstanding load/store unit: registers one request, drives one
// memory cycle, waits RD_LATENCY cycles for load data and holds the response.
module lsu #(
    parameter int RD_LATENCY = 1
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    localparam logic [1:0] LAT = 2'(RD_LATENCY);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic        byte_q, byte_d;
    logic        signed_q, signed_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  cnt_q, cnt_d;

    logic        resp_valid_q, resp_valid_d;
    logic [15:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_be_q, mem_be_d;
    logic        mem_bs_q, mem_bs_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;

    logic [15:0] load_data;

    always_comb begin
        load_data = bus.mem_rdata;
        if (byte_q && signed_q) begin
            load_data = {{8{bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
        end
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        byte_d       = byte_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d  = bus.req_write;
                    byte_d   = bus.req_byte;
                    signed_d = bus.req_signed;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    // Misaligned word access answers with an error and never touches memory
                    if (!bus.req_byte && bus.req_addr[0]) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!bus.mem_wait) begin
                    if (write_q) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        resp_rdata_d = '0;
                    end else begin
                        state_d = RDWAIT;
                        cnt_d   = LAT;
                    end
                end
            end
            RDWAIT: begin
                if (!bus.mem_wait) begin
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        resp_rdata_d = load_data;
                    end
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory controls are registered from the next state so they are live
    // exactly while the FSM sits in ISSUE and zero everywhere else.
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_be_d    = 1'b0;
        mem_bs_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (state_d == ISSUE) begin
            mem_en_d    = 1'b1;
            mem_we_d    = write_d;
            mem_be_d    = byte_d;
            mem_bs_d    = addr_d[0];
            mem_addr_d  = {1'b0, addr_d[15:1]};
            if (write_d) begin
                mem_wdata_d = byte_d ? {wdata_d[7:0], wdata_d[7:0]} : wdata_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            byte_q       <= 1'b0;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 1'b0;
            mem_bs_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            byte_q       <= byte_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_bs_q     <= mem_bs_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.req_ready       = (state_q == IDLE);
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_rdata      = resp_rdata_q;
    assign bus.resp_err        = resp_err_q;
    assign bus.mem_en          = mem_en_q;
    assign bus.mem_we          = mem_we_q;
    assign bus.mem_byte_enable = mem_be_q;
    assign bus.mem_byte_select = mem_bs_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_wdata       = mem_wdata_q;

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter RD_LATENCY, default 1: cycles from memory issue cycle to the cycle in which mem_rdata is valid; legal range 1..3.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  load/store request present.
REQ-006 req_ready  out  1  high only in IDLE; request accepted on an edge with req_valid&&req_ready.
REQ-007 req_write  in  1  1=store, 0=load.
REQ-008 req_byte  in  1  1=byte access, 0=word access.
REQ-009 req_signed  in  1  byte loads: 1=sign-extend, 0=zero-extend.
REQ-010 req_addr  in  16  byte address.
REQ-011 req_wdata  in  16  store data; byte stores use bits [7:0].
REQ-012 resp_valid  out  1  response present; held until resp_ready.
REQ-013 resp_ready  in  1  consumer accepts response.
REQ-014 resp_rdata  out  16  load result; 0 for stores and errors.
REQ-015 resp_err  out  1  misaligned word access.
REQ-016 mem_en, mem_we, mem_byte_enable, mem_byte_select  out  1 each  memory control to the RAM port-1 stage.
REQ-017 mem_addr  out  16  word address to memory.
REQ-018 mem_wdata  out  16  write data to memory.
REQ-019 mem_rdata  in  16  memory read data (already lane-selected and zero-extended for byte accesses).
REQ-020 mem_wait  in  1  memory stall.

Function
REQ-021 States: IDLE, ISSUE, RDWAIT, RESP.
REQ-022 Request fields are registered on acceptance; later changes on req_* have no effect until the next acceptance.
REQ-023 IDLE -> RESP with resp_err=1 and no memory cycle when req_byte=0 and req_addr[0]=1.
REQ-024 IDLE -> ISSUE on every other accepted request.
REQ-025 ISSUE: mem_en=1; mem_we=req_write; mem_byte_enable=req_byte; mem_byte_select=req_addr[0]; mem_addr={1'b0,req_addr[15:1]}.
REQ-026 ISSUE, mem_wdata: {wdata[7:0],wdata[7:0]} for byte stores, wdata for word stores.
REQ-027 All mem_* outputs are registered and are 0 in every state other than ISSUE.
REQ-028 ISSUE with mem_wait=1: stay in ISSUE with the memory outputs held stable.
REQ-029 ISSUE with mem_wait=0: stores go to RESP; loads go to RDWAIT with the latency counter loaded to RD_LATENCY.
REQ-030 RDWAIT: the counter decrements on each edge with mem_wait=0 and freezes while mem_wait=1.
REQ-031 RDWAIT capture: on the edge where the counter is 1 and mem_wait=0, capture mem_rdata into resp_rdata and go to RESP.
REQ-032 Byte-load extension: signed byte loads set resp_rdata[15:8] to captured bit 7; unsigned byte loads use mem_rdata unchanged.
REQ-033 Latency: a store accepted at edge 0 gives ISSUE in cycle 1 and resp_valid in cycle 2.
REQ-034 Latency: a load gives resp_valid in cycle 2+RD_LATENCY, assuming no mem_wait.
REQ-035 RESP: resp_valid=1 with resp_rdata/resp_err stable; resp_valid&&resp_ready -> IDLE, clearing resp_valid, resp_rdata and resp_err.
REQ-036 No back-to-back overlap: at most one request is in flight, and req_ready=0 outside IDLE.
REQ-037 mem_wait is ignored in IDLE and RESP.

Reset
REQ-038 rst low: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, all mem_* outputs 0, counter=0, asynchronously.
REQ-039 Reset mid-operation aborts the in-flight request; no response is produced and mem_en/mem_we drop immediately.
REQ-040 Operation resumes on the first rising edge after rst returns high.

Verification
REQ-041 Word store addr=0x0010 data=0xBEEF -> cycle 1: mem_addr=0x0008, mem_we=1, byte_enable=0, wdata=0xBEEF; cycle 2: resp_valid=1, err=0.
REQ-042 Signed byte load addr=0x0021, RD_LATENCY=2, mem_rdata=0x0080 -> byte_select=1, mem_addr=0x0010; resp_rdata=0xFF80 in cycle 4; unsigned gives 0x0080.
REQ-043 Word load addr=0x0003 -> no mem_en pulse; cycle 1: resp_valid=1, resp_err=1, resp_rdata=0.
REQ-044 mem_wait high 3 cycles during ISSUE, then 2 cycles in RDWAIT -> outputs held; load response delayed 5 cycles; data is the value present at capture.
REQ-045 resp_ready low 4 cycles -> resp_valid and data stable, req_ready=0; a new req_valid is not accepted until after the handshake.
REQ-046 rst pulsed low during RDWAIT -> all outputs at reset values at once; no response appears; the next request completes normally.
